// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam logic [31:0] SYSCALL_INST = 32'h0000_000c;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// Entry storage for fetch_queue: one synchronous write port, one asynchronous read port.
module fetch_queue_mem
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               i_we,
    input  logic [AW-1:0]      i_waddr,
    input  fetch_entry_t       i_wdata,
    input  logic [AW-1:0]      i_raddr,
    output fetch_entry_t       o_rdata
);

    fetch_entry_t r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Head must be visible in the same cycle decode samples it.
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode prefetch queue with flush, NOP bubbles and sticky syscall halt.
// Optional same-cycle bypass when empty is enabled by defining FETCH_QUEUE_BYPASS_EN.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_is_nop,
    input  logic        out_ready,
    output logic        halted
);

    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_halted;

    logic          w_empty;
    logic          w_full;
    logic          w_bypass;
    logic          w_pop;
    logic          w_mem_push;
    logic          w_mem_pop;
    fetch_entry_t  w_wdata;
    fetch_entry_t  w_head;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_COUNT);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign w_bypass = w_empty & in_valid & ~flush & ~r_halted;
`else
    assign w_bypass = 1'b0;
`endif

    assign w_wdata = '{pc: in_pc, inst: in_inst};

    fetch_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_mem_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_wdata),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_head)
    );

    assign in_ready  = ~w_full & ~r_halted;
    assign out_valid = (~w_empty & ~r_halted) | w_bypass;

    always_comb begin
        out_pc   = 32'h0;
        out_inst = NOP_INST;
        if (w_bypass) begin
            out_pc   = in_pc;
            out_inst = in_inst;
        end else if (out_valid) begin
            out_pc   = w_head.pc;
            out_inst = w_head.inst;
        end
    end

    assign out_is_nop = ~out_valid;
    assign halted     = r_halted;

    // A bypassed entry consumed in the same cycle never touches storage.
    assign w_pop      = out_valid & out_ready & ~flush;
    assign w_mem_pop  = w_pop & ~w_bypass;
    assign w_mem_push = in_valid & in_ready & ~flush & ~(w_bypass & out_ready);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_mem_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_mem_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_mem_push, w_mem_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Halt survives flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_halted <= 1'b0;
        end else if (w_pop && out_inst == SYSCALL_INST) begin
            r_halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios then random traffic against a queue model.
module tb_fetch_queue;

    localparam int DEPTH = 4;
    localparam logic [31:0] SYSCALL = 32'h0000_000c;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_is_nop;
    logic        out_ready;
    logic        halted;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: ordered list of pending {pc, inst} pairs plus halt flag.
    logic [63:0] model_q[$];
    bit          model_halted;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_pc      (in_pc),
        .in_inst    (in_inst),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_pc     (out_pc),
        .out_inst   (out_inst),
        .out_is_nop (out_is_nop),
        .out_ready  (out_ready),
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, compare outputs with the model, advance the model.
    task automatic step(input bit iv, input logic [31:0] pc, input logic [31:0] inst,
                        input bit ordy, input bit fl, input bit rst);
        bit          exp_ready, exp_valid, byp, pop, push;
        logic [31:0] exp_pc, exp_inst;
        reset     = rst;
        in_valid  = iv;
        in_pc     = pc;
        in_inst   = inst;
        out_ready = ordy;
        flush     = fl;
        #1;
        exp_ready = (model_q.size() != DEPTH) && !model_halted;
        byp       = BYPASS && model_q.size() == 0 && iv && !fl && !model_halted;
        exp_valid = (model_q.size() != 0 && !model_halted) || byp;
        exp_pc    = 32'h0;
        exp_inst  = 32'h0;
        if (byp) begin
            exp_pc   = pc;
            exp_inst = inst;
        end else if (exp_valid) begin
            exp_pc   = model_q[0][63:32];
            exp_inst = model_q[0][31:0];
        end
        check("in_ready",   {31'b0, in_ready},   {31'b0, exp_ready});
        check("out_valid",  {31'b0, out_valid},  {31'b0, exp_valid});
        check("out_is_nop", {31'b0, out_is_nop}, {31'b0, !exp_valid});
        check("out_pc",     out_pc,   exp_pc);
        check("out_inst",   out_inst, exp_inst);
        check("halted",     {31'b0, halted},     {31'b0, model_halted});
        pop  = exp_valid && ordy && !fl;
        push = iv && exp_ready && !fl;
        $display("t=%0t rst=%0b fl=%0b push=%0b pc_in=%h pop=%0b pc_out=%h occ=%0d halt=%0b",
                 $time, rst, fl, push, pc, pop, exp_pc, model_q.size(), model_halted);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_halted = 1'b0;
        end else if (fl) begin
            model_q.delete();
        end else begin
            if (pop && exp_inst == SYSCALL) model_halted = 1'b1;
            if (pop && !byp) void'(model_q.pop_front());
            if (push && !(byp && ordy)) model_q.push_back({pc, inst});
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_inst = '0;
        out_ready = 1'b0; flush = 1'b0;
        model_halted = 1'b0;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);                       // reset values

        // In-order streaming with decode ready
        for (int i = 0; i < 4; i++) step(1, 32'(i*4), 32'h1000 + 32'(i), 1, 0, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 0, 1, 0, 0);

        // Back-pressure: fill, hold off fifth, then drain
        for (int i = 0; i < 5; i++) step(1, 32'h200 + 32'(i*4), 32'h2000 + 32'(i), 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 0, 0);

        // Flush drops contents and the concurrent input
        for (int i = 0; i < 3; i++) step(1, 32'h300 + 32'(i*4), 32'h3000 + 32'(i), 0, 0, 0);
        step(1, 32'h40, 32'h4000, 1, 1, 0);
        step(1, 32'h100, 32'h5000, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0, 0);

        // Syscall halt is sticky across flush, cleared by reset
        step(1, 32'h500, 32'h2002000a, 1, 0, 0);
        step(1, 32'h504, SYSCALL, 1, 0, 0);
        step(1, 32'h508, 32'h6000, 1, 0, 0);
        step(1, 32'h50c, 32'h6001, 1, 0, 0);
        step(1, 32'h510, 32'h6002, 1, 1, 0);
        step(1, 32'h514, 32'h6003, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Reset while half full
        step(1, 32'h600, 32'h7000, 0, 0, 0);
        step(1, 32'h604, 32'h7001, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Wrap with interleaved pops
        for (int i = 0; i < 10; i++) step(1, 32'h700 + 32'(i*4), 32'h8000 + 32'(i), i[0], 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);

        // Random traffic; reset occasionally so halts do not freeze the run
        for (int i = 0; i < 600; i++) begin
            logic [31:0] rpc, rinst;
            bit          rst_now;
            rpc     = $urandom() & 32'hffff_fffc;
            rinst   = ($urandom_range(0, 24) == 0) ? SYSCALL : $urandom();
            rst_now = model_halted ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 80) == 0);
            step($urandom_range(0, 3) != 0, rpc, rinst, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 15) == 0, rst_now);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction prefetch queue between the fetch stage and the decode stage. Each cycle it accepts one {pc, inst} pair from fetch and presents entries in order to decode. Decode back-pressure is absorbed by the queue instead of stalling the PC. The queue flushes on any taken redirect (jump, jump-register, branch), supplies NOP bubbles when empty, and raises a sticky halt once a syscall instruction is consumed.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports (one clock; reset is synchronous and active-high):
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  fetch presents a valid pair
- in_pc  input  32  PC of the fetched instruction
- in_inst  input  32  fetched instruction word
- in_ready  output  1  queue accepts the pair this cycle
- flush  input  1  redirect taken; discard all contents and the current input
- out_valid  output  1  head entry valid for decode
- out_pc  output  32  head PC
- out_inst  output  32  head instruction; 32'h0000_0000 (NOP) when out_valid=0
- out_is_nop  output  1  high when out_valid=0 (bubble to decode)
- out_ready  input  1  decode consumes head this cycle (low = stall)
- halted  output  1  sticky; syscall consumed

## Operation
- Push: in_valid & in_ready & !flush writes {in_pc, in_inst} at wr_ptr; wr_ptr increments modulo DEPTH.
- Pop: out_valid & out_ready & !flush advances rd_ptr modulo DEPTH.
- count (AW+1 bits) tracks occupancy. Simultaneous push and pop leaves count unchanged.
- in_ready = (count != DEPTH) & !halted. When full, a same-cycle pop does not enable a push.
- out_valid = (count != 0) & !halted. Head data is read combinationally from rd_ptr.
- Empty or halted: out_pc = 32'h0, out_inst = 32'h0, out_is_nop = 1.
- Flush has highest priority. On the next edge count=0 and rd_ptr=wr_ptr=0. The input in the flush cycle is dropped and no pop is counted.
- Halt: when a pop occurs with out_inst == 32'h0000_000c, halted=1 from the next cycle. It stays set until reset. Flush does not clear it.
- Reset mid-operation: all contents are discarded, the same as a flush, and halted is cleared.

## Timing
- Reset values: count=0, rd_ptr=wr_ptr=0, halted=0. Resulting outputs: out_valid=0, out_is_nop=1, out_pc=0, out_inst=0, in_ready=1.
- Latency (bypass off): an entry pushed at edge N is visible on out_* during cycle N+1.
- Throughput: one push and one pop per cycle sustained.
- out_* hold stable while out_valid=1 and out_ready=0.

## Configuration
- FETCH_QUEUE_BYPASS_EN defined:
  - When count==0, in_valid=1, flush=0 and halted=0, out_valid=1 and out_pc/out_inst reflect in_pc/in_inst combinationally.
  - If out_ready=1 in that cycle, the entry is consumed and not stored (count stays 0).
  - The halt check also applies to the bypassed instruction.
- FETCH_QUEUE_BYPASS_EN undefined: always at least one cycle of latency, as described under Timing.

## Structure
- Shared package fetch_pkg:
  - NOP_INST = 32'h0000_0000
  - SYSCALL_INST = 32'h0000_000c
  - typedef struct packed fetch_entry_t {pc[31:0], inst[31:0]}
- One sub-module, fetch_queue_mem: DEPTH × fetch_entry_t array with a synchronous write port and an asynchronous read port.
- Pointer, count, halt and bypass logic live in fetch_queue.

## Test plan
- Reset, then push PCs 0x0, 0x4, 0x8, 0xC with out_ready=1 → out_pc sequence 0x0, 0x4, 0x8, 0xC starting 1 cycle after the first push (0 cycles with bypass); in_ready stays 1.
- out_ready=0, push 5 pairs → in_ready falls after the 4th; the 5th is held off; out_pc stays 0x0. Raise out_ready → the 4 entries drain in order.
- Fill 3 entries, assert flush together with in_valid (pc 0x40) → next cycle out_valid=0, out_inst=0, out_is_nop=1. Pushing pc 0x100 → it is the next popped entry.
- Push 0x2002000a then 0x0000000c with out_ready=1 → halted=1 the cycle after the syscall pop. Afterwards in_ready=0 and out_valid=0 despite in_valid; a flush leaves halted=1. Reset clears it.
- Wrap: 10 pushes interleaved with pops, DEPTH=4 → order preserved across pointer wrap; count never exceeds 4.
- Assert reset while half full → next cycle all outputs return to their reset values.
